// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing, line/frame total derivation and sync polarity helpers
package vga_timing_pkg;
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BACK = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BACK = 33;
  localparam int DEF_RGB_W = 12;
  localparam int SYNC_ACT_LOW = 0;
  localparam int SYNC_ACT_HIGH = 1;
  function automatic int timing_total(input int disp, input int front, input int sync, input int back);
    return disp + front + sync + back;
  endfunction
  function automatic logic sync_inactive(input int pol);
    return pol == SYNC_ACT_LOW;
  endfunction
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: enable-gated shift register of DEPTH stages (0 = plain wire), sync reset to RST_VAL
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] tap [DEPTH+1];
  assign tap[0] = din;
  for (genvar g = 1; g <= DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] st_q, st_d;
    always_comb st_d = en ? tap[g-1] : st_q;
    always_ff @(posedge clk) st_q <= rst ? RST_VAL : st_d;
    assign tap[g] = st_q;
  end
  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, en};
  end
  assign dout = tap[DEPTH];
endmodule

// File: rtl/vga_timing_pipe.sv
// vga_timing_pipe: VGA timing counters, pixel-tick divider and latency-aligned RGB/sync output stage
module vga_timing_pipe
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CNT_W = 10,
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT = DEF_H_FRONT,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BACK = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT = DEF_V_FRONT,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BACK = DEF_V_BACK,
  parameter int SYNC_POL = SYNC_ACT_LOW,
  parameter int RGB_W = DEF_RGB_W,
  parameter int PIPE_DEPTH = 1
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic [RGB_W-1:0] rgb_in,
  output logic             p_tick,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             video_on,
  output logic             frame_start,
  output logic             hsync,
  output logic             vsync,
  output logic [RGB_W-1:0] rgb
);
  localparam int H_TOTAL = timing_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = timing_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic INACT = sync_inactive(SYNC_POL);
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             p_tick_q, p_tick_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             x_wrap, von, hs_act, vs_act, von_d, hs_act_d, vs_act_d;
  always_comb begin
    x_wrap = x_q == X_LAST;
    p_tick_d = div_cnt_q == DIV_LAST;
    div_cnt_d = p_tick_d ? '0 : div_cnt_q + 1'b1;
    x_d = p_tick_q ? (x_wrap ? '0 : x_q + 1'b1) : x_q;
    y_d = p_tick_q && x_wrap ? (y_q == Y_LAST ? '0 : y_q + 1'b1) : y_q;
    von = int'(x_q) < H_DISPLAY && int'(y_q) < V_DISPLAY;
    hs_act = int'(x_q) >= HS_START && int'(x_q) < HS_START + H_SYNC;
    vs_act = int'(y_q) >= VS_START && int'(y_q) < VS_START + V_SYNC;
    rgb_d = p_tick_q ? (von_d ? rgb_in : '0) : rgb_q;
    hsync_d = p_tick_q ? hs_act_d ^ INACT : hsync_q;
    vsync_d = p_tick_q ? vs_act_d ^ INACT : vsync_q;
  end
  // Covers the pixel generator's latency; the output register adds the final tick.
  vga_delay_line #(.WIDTH(3), .DEPTH(PIPE_DEPTH - 1)) u_align (
    .clk (clk_100MHz),
    .rst (reset),
    .en  (p_tick_q),
    .din ({von, hs_act, vs_act}),
    .dout({von_d, hs_act_d, vs_act_d})
  );
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      div_cnt_q <= '0;
      p_tick_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      hsync_q <= INACT;
      vsync_q <= INACT;
      rgb_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      p_tick_q <= p_tick_d;
      x_q <= x_d;
      y_q <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q <= rgb_d;
    end
  end
  assign p_tick = p_tick_q;
  assign x = x_q;
  assign y = y_q;
  assign video_on = von;
  assign frame_start = p_tick_q && x_wrap && y_q == Y_LAST;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign rgb = rgb_q;
endmodule

// File: doc/vga_timing_pipe.md
Name: vga_timing_pipe

Overview:
- Parametrised successor to the pong front end: one block holds the VGA timing generator, the pixel-tick divider and the aligned RGB/sync output stage.
- Sits between the board clock and the VGA DAC/port.
- Feeds x/y/video_on to the pixel generator and takes its colour back.
- Adds over the fixed 640x480 design:
  - configurable timing;
  - configurable sync polarity;
  - a configurable pixel-generator latency, with syncs delayed to match;
  - forced blanking;
  - a frame_start strobe.

Parameters:
- CLK_DIV, 4, clk_100MHz cycles per pixel tick (>=1).
- CNT_W, 10, width of x/y counters.
- H_DISPLAY, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch, in ticks.
- H_SYNC, 96, hsync pulse width, in ticks.
- H_BACK, 48, horizontal back porch, in ticks.
- V_DISPLAY, 480, visible lines.
- V_FRONT, 10, vertical front porch, in lines.
- V_SYNC, 2, vsync pulse width, in lines.
- V_BACK, 33, vertical back porch, in lines.
- SYNC_POL, 0, 0 = active-low syncs, 1 = active-high syncs.
- RGB_W, 12, colour bus width.
- PIPE_DEPTH, 1, output alignment depth in ticks (1..8); the pixel generator latency equals PIPE_DEPTH-1 ticks.

Ports:
- clk_100MHz  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rgb_in  in  RGB_W  colour from the pixel generator.
- p_tick  out  1  one-cycle pixel-rate enable.
- x  out  CNT_W  current horizontal count.
- y  out  CNT_W  current vertical count.
- video_on  out  1  (x,y) lies in the visible area; undelayed.
- frame_start  out  1  one-cycle pulse on the tick that wraps (x,y) to (0,0).
- hsync  out  1  aligned, registered horizontal sync.
- vsync  out  1  aligned, registered vertical sync.
- rgb  out  RGB_W  aligned, registered, blanked colour.

Behaviour:
- Totals: H_TOTAL = sum of the four H_* parameters (800); V_TOTAL = sum of the four V_* parameters (525).
- Reset (synchronous):
  - div_cnt, x and y = 0; p_tick = 0; frame_start = 0.
  - hsync and vsync = inactive level (~SYNC_POL); rgb = 0.
  - All delay stages = inactive sync level / video_on 0.
  - video_on reads 1, since it decodes (0,0).
  - Reset mid-frame restarts from (0,0) on the next cycle with no partial tick.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - p_tick is registered and high for exactly the cycle after div_cnt == CLK_DIV-1.
  - CLK_DIV = 1 gives p_tick held high continuously from the first cycle after reset.
- Counters (advance only on p_tick):
  - x increments; x == H_TOTAL-1 wraps x to 0.
  - On that wrap, y increments; y == V_TOTAL-1 wraps y to 0.
- frame_start = p_tick && x == H_TOTAL-1 && y == V_TOTAL-1.
- Raw decodes (combinational from the counters):
  - video_on = x < H_DISPLAY && y < V_DISPLAY.
  - hs_act = H_DISPLAY+H_FRONT <= x < H_DISPLAY+H_FRONT+H_SYNC.
  - vs_act = V_DISPLAY+V_FRONT <= y < V_DISPLAY+V_FRONT+V_SYNC.
- Alignment:
  - video_on is delayed PIPE_DEPTH-1 ticks to give von_d (PIPE_DEPTH = 1 means no delay).
  - hs_act and vs_act are delayed PIPE_DEPTH-1 ticks, then registered once more on p_tick.
  - Every delay stage shifts only on p_tick.
- Output register (on p_tick):
  - rgb <= von_d ? rgb_in : 0.
  - hsync <= hs_act_d ^ ~SYNC_POL.
  - vsync <= vs_act_d ^ ~SYNC_POL.
  - All outputs hold between ticks.
- Net latency: counter state to pin = PIPE_DEPTH ticks, identical for rgb, hsync and vsync.
- Constraint: H_TOTAL and V_TOTAL must be <= 2**CNT_W. No overflow handling is required beyond that.

Decomposition:
- Package vga_timing_pkg holds:
  - default 640x480@60 timing constants (H_*/V_*);
  - the H_TOTAL/V_TOTAL derivation;
  - the default RGB_W;
  - sync polarity constants.
- Sub-module vga_delay_line (WIDTH, DEPTH, enable-gated shift register with synchronous reset value), instantiated for the {video_on, hs_act, vs_act} bundle.

Test Plan:
- Reset values: hold reset 5 cycles, then release.
  - During reset: rgb = 0, hsync = vsync = 1, p_tick = 0.
  - After release: first p_tick appears 4 cycles later; x = 1 after that tick.
- Frame period, defaults: consecutive frame_start pulses are exactly 800*525*4 = 1,680,000 clk_100MHz cycles apart.
- Sync timing, PIPE_DEPTH = 1:
  - hsync falls on the tick that samples x = 656 and stays low 96 ticks (384 clocks).
  - vsync is low for lines 490..491 only.
- Blanking: rgb_in = 12'hFFF constant.
  - rgb = FFF for 640 ticks per line, then 0 for 160 ticks.
  - rgb = 0 for all of lines 480..524.
- Alignment: PIPE_DEPTH = 3, pixel-gen model = 2-tick register chain of x[3:0].
  - rgb == (x_orig & 12'h00F) when hsync falls 3 ticks after x = 656.
  - rgb is zero 3 ticks after x = 640.
- Small config: CLK_DIV = 1, SYNC_POL = 1, H = 8/1/2/1, V = 4/1/1/1.
  - p_tick is constant 1.
  - hsync is high at x = 9..10 (output one tick later).
  - Frame is 12*7 = 84 cycles.
  - Assert reset at x = 5 → next cycle x = 0, hsync = 0.
